// File: rtl/evm_vote_controller.sv
// Electronic voting machine ballot controller: one vote per issued ballot,
// confirm hold-off, saturating vote tally and a terminal poll-closed state.
module evm_vote_controller #(
    parameter int NUM_CANDIDATES = 8,
    parameter int CONFIRM_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ballot_enable,
    input  logic [3:0] candidate_sel,
    input  logic       select_valid,
    input  logic       poll_close,
    output logic       vote_cast,
    output logic [3:0] candidate_number,
    output logic       ready_led,
    output logic       confirm_led,
    output logic       reject,
    output logic [7:0] total_votes,
    output logic       poll_closed
);

    typedef enum logic [2:0] {IDLE, READY, CAST, CONFIRM, CLOSED} state_t;

    localparam int             CW       = $clog2(CONFIRM_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CONFIRM_CYCLES - 1);
    localparam logic [4:0]     MAX_SEL  = 5'(NUM_CANDIDATES);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic [3:0]    cand_q, cand_d;
    logic [7:0]    total_q, total_d;
    logic          reject_q, reject_d;
    logic          sel_in_range;

    assign sel_in_range = (candidate_sel != 4'd0) && ({1'b0, candidate_sel} <= MAX_SEL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            cand_q   <= 4'd0;
            total_q  <= 8'd0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            cand_q   <= cand_d;
            total_q  <= total_d;
            reject_q <= reject_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        cand_d   = cand_q;
        total_d  = total_q;
        reject_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (poll_close)         state_d = CLOSED;
                else if (ballot_enable) state_d = READY;
            end
            READY: begin
                // Closing wins over a simultaneous selection: no vote, no reject.
                if (poll_close) begin
                    state_d = CLOSED;
                end else if (select_valid) begin
                    if (sel_in_range) begin
                        cand_d  = candidate_sel;
                        state_d = CAST;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            CAST: begin
                pend_d  = pend_q | poll_close;
                total_d = (total_q != 8'hFF) ? total_q + 8'd1 : total_q;
                cnt_d   = '0;
                state_d = CONFIRM;
            end
            CONFIRM: begin
                pend_d = pend_q | poll_close;
                if (cnt_q == CNT_LAST) begin
                    state_d = (pend_q | poll_close) ? CLOSED : IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CLOSED: ;
            default: state_d = IDLE;
        endcase
    end

    assign vote_cast        = (state_q == CAST);
    assign ready_led        = (state_q == READY);
    assign confirm_led      = (state_q == CONFIRM);
    assign poll_closed      = (state_q == CLOSED);
    assign candidate_number = cand_q;
    assign total_votes      = total_q;
    assign reject           = reject_q;

endmodule

// File: tb/tb_evm_vote_controller.sv
// Self-checking bench: a ballot-level model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_evm_vote_controller;

    localparam int NC   = 8;
    localparam int CONF = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ballot_enable = 1'b0;
    logic [3:0] candidate_sel = 4'd0;
    logic       select_valid = 1'b0;
    logic       poll_close = 1'b0;
    logic       vote_cast;
    logic [3:0] candidate_number;
    logic       ready_led;
    logic       confirm_led;
    logic       reject;
    logic [7:0] total_votes;
    logic       poll_closed;

    int errors = 0;
    int checks = 0;

    evm_vote_controller #(.NUM_CANDIDATES(NC), .CONFIRM_CYCLES(CONF)) dut (
        .clk(clk), .rst_n(rst_n), .ballot_enable(ballot_enable),
        .candidate_sel(candidate_sel), .select_valid(select_valid),
        .poll_close(poll_close), .vote_cast(vote_cast),
        .candidate_number(candidate_number), .ready_led(ready_led),
        .confirm_led(confirm_led), .reject(reject),
        .total_votes(total_votes), .poll_closed(poll_closed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Ballot-level model: a ballot is open or not; an accepted vote occupies
    // CONF+1 cycles (the strobe cycle followed by the confirm window).
    bit m_started = 0;
    bit m_ballot, m_closed, m_pend, m_reject;
    int m_vote_left, m_votes, m_cand;

    always @(posedge clk) begin
        m_reject = 0;
        if (!rst_n) begin
            m_started = 1; m_ballot = 0; m_closed = 0; m_pend = 0;
            m_vote_left = 0; m_votes = 0; m_cand = 0;
        end else if (m_closed) begin
            // nothing changes once polling is over
        end else if (m_vote_left > 0) begin
            if (poll_close) m_pend = 1;
            if (m_vote_left == CONF + 1 && m_votes < 255) m_votes++;
            m_vote_left--;
            if (m_vote_left == 0 && m_pend) m_closed = 1;
        end else if (m_ballot) begin
            if (poll_close) begin
                m_closed = 1; m_ballot = 0;
            end else if (select_valid) begin
                if (candidate_sel >= 1 && candidate_sel <= NC) begin
                    m_cand = candidate_sel; m_ballot = 0; m_vote_left = CONF + 1;
                end else begin
                    m_reject = 1;
                end
            end
        end else begin
            if (poll_close)         m_closed = 1;
            else if (ballot_enable) m_ballot = 1;
        end
        #1;
        if (m_started) begin
            chk("vote_cast", vote_cast, int'(m_vote_left == CONF + 1));
            chk("confirm_led", confirm_led, int'(m_vote_left >= 1 && m_vote_left <= CONF));
            chk("ready_led", ready_led, int'(m_ballot));
            chk("reject", reject, int'(m_reject));
            chk("candidate_number", candidate_number, m_cand);
            chk("total_votes", total_votes, m_votes);
            chk("poll_closed", poll_closed, int'(m_closed));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0; ballot_enable = 0; select_valid = 0; poll_close = 0;
        cyc(); cyc();
        rst_n = 1;
    endtask

    task automatic do_vote(input logic [3:0] c, output bit cast_seen);
        ballot_enable = 1; cyc();
        ballot_enable = 0; select_valid = 1; candidate_sel = c; cyc();
        select_valid = 0; cast_seen = vote_cast;
        repeat (CONF + 1) cyc();
    endtask

    initial begin
        bit seen;
        cyc();
        do_reset();
        chk("rst_all_zero", {vote_cast, candidate_number, ready_led, confirm_led,
                             reject, total_votes, poll_closed}, 0);

        // Normal vote for candidate 3
        ballot_enable = 1; cyc(); ballot_enable = 0;
        chk("n_ready", ready_led, 1);
        select_valid = 1; candidate_sel = 4'd3; cyc(); select_valid = 0;
        chk("n_cast", vote_cast, 1);
        chk("n_cand", candidate_number, 3);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("n_confirm", confirm_led, 1);
            chk("n_nocast", vote_cast, 0);
        end
        chk("n_total", total_votes, 1);
        cyc();
        chk("n_confirm_end", confirm_led, 0);
        chk("n_idle_ready", ready_led, 0);

        // Invalid then valid selection
        ballot_enable = 1; cyc(); ballot_enable = 0;
        select_valid = 1; candidate_sel = 4'd0; cyc();
        chk("inv0_reject", reject, 1);
        chk("inv0_ready", ready_led, 1);
        candidate_sel = 4'd9; cyc();
        chk("inv9_reject", reject, 1);
        chk("inv9_nocast", vote_cast, 0);
        chk("inv_cand_kept", candidate_number, 3);
        candidate_sel = 4'd1; cyc();
        chk("v1_cast", vote_cast, 1);
        chk("v1_reject_clear", reject, 0);
        // Hold select_valid through CAST/CONFIRM and pulse ballot_enable in CONFIRM
        candidate_sel = 4'd2; cyc();
        ballot_enable = 1; cyc(); ballot_enable = 0;
        repeat (3) cyc();
        select_valid = 0;
        chk("v1_total", total_votes, 2);
        chk("no_requeue_ready", ready_led, 0);
        chk("v1_cand", candidate_number, 1);

        // Close priority in IDLE
        do_reset();
        ballot_enable = 1; poll_close = 1; cyc(); poll_close = 0;
        chk("close_prio", poll_closed, 1);
        chk("close_noready", ready_led, 0);
        cyc(); ballot_enable = 0;
        chk("closed_ignore", ready_led, 0);

        // Deferred close during CONFIRM
        do_reset();
        ballot_enable = 1; cyc(); ballot_enable = 0;
        select_valid = 1; candidate_sel = 4'd5; cyc(); select_valid = 0;
        cyc(); poll_close = 1; cyc(); poll_close = 0;
        repeat (3) cyc();
        chk("defer_closed", poll_closed, 1);
        chk("defer_total", total_votes, 1);
        ballot_enable = 1; cyc(); ballot_enable = 0;
        chk("defer_ignore", ready_led, 0);

        // Reset during CONFIRM with five votes recorded
        do_reset();
        for (int i = 0; i < 5; i++) do_vote(4'd4, seen);
        chk("mid_total5", total_votes, 5);
        ballot_enable = 1; cyc(); ballot_enable = 0;
        select_valid = 1; candidate_sel = 4'd6; cyc(); select_valid = 0;
        cyc(); cyc();
        rst_n = 0; cyc(); rst_n = 1;
        chk("mid_rst_zero", {vote_cast, candidate_number, ready_led, confirm_led,
                             reject, total_votes, poll_closed}, 0);

        // Saturation
        do_reset();
        for (int i = 0; i < 255; i++) do_vote(4'(1 + (i % NC)), seen);
        chk("sat_255", total_votes, 255);
        do_vote(4'd8, seen);
        chk("sat_256_cast", int'(seen), 1);
        chk("sat_hold", total_votes, 255);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            ballot_enable = ($urandom_range(0, 99) < 30);
            select_valid  = ($urandom_range(0, 99) < 40);
            candidate_sel = 4'($urandom_range(0, 15));
            poll_close    = ($urandom_range(0, 99) == 0);
            rst_n         = !(($urandom_range(0, 199) == 0) ||
                              (poll_closed && $urandom_range(0, 9) == 0));
            cyc();
        end
        rst_n = 1; ballot_enable = 0; select_valid = 0; poll_close = 0;
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
